regfile_wb_queue: RTL

Writeback queue that feeds the single write port of the 32×16 register file (`RegWrite`, `Rd`, `Write_data`). It accepts results from two producers, the ALU and the load unit, through valid/ready handshakes and buffers them in a small FIFO. It drains at most one write per cycle into the register file. It also exports a pending-write scoreboard, which decode uses to stall on source registers that still have a queued write.

---
 rtl/regfile_wb_queue_pkg.sv | 13 +
 rtl/regfile_wb_queue_if.sv | 36 +++
 rtl/regfile_wb_queue_fifo.sv | 61 ++++++
 rtl/regfile_wb_queue.sv | 124 ++++++++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared widths and the writeback entry type for the register-file writeback queue.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle of producer handshakes, register-file write port and decode scoreboard query.
interface regfile_wb_queue_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              RegWrite;
    logic [ADDR_W-1:0] Rd;
    logic [DATA_W-1:0] Write_data;
    logic [ADDR_W-1:0] chk_rs1;
    logic [ADDR_W-1:0] chk_rs2;
    logic              pend_rs1;
    logic              pend_rs2;
    logic [CW-1:0]     count;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, chk_rs1, chk_rs2,
        output alu_ready, ld_ready, RegWrite, Rd, Write_data, pend_rs1, pend_rs2, count
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, chk_rs1, chk_rs2,
        input  alu_ready, ld_ready, RegWrite, Rd, Write_data, pend_rs1, pend_rs2, count
    );

endinterface

// File: rtl/regfile_wb_queue_fifo.sv
// Dual-push / single-pop FIFO of writeback entries; push_a is enqueued ahead of push_b.
module wbq_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_a_i,
    input  wb_entry_t           ent_a_i,
    input  logic                push_b_i,
    input  wb_entry_t           ent_b_i,
    input  logic                pop_i,
    output wb_entry_t           head_o,
    output logic [CW-1:0]       count_o,
    output logic [DEPTH-1:0]    ent_valid_o,
    output logic [ADDR_W-1:0]   ent_rd_o [DEPTH]
);

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_a_i) + PW'(push_b_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_a_i) mem_q[wr_ptr_q] <= ent_a_i;
        if (push_b_i) mem_q[wr_ptr_q + PW'(1)] <= ent_b_i;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid_o[i] = {1'b0, PW'(i) - rd_ptr_q} < count_q;
            ent_rd_o[i]    = mem_q[i].rd;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue merging ALU and load results into the single register-file write port.
// Optional same-edge bypass into the output register when REGFILE_WBQ_BYPASS_EN is defined.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    regfile_wb_queue_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]     count;
    wb_entry_t         head, ld_ent, alu_ent, ent_a, ent_b, byp_ent;
    logic              push_a, push_b, pop, byp;
    logic              ld_push, alu_push, ld_ready, alu_ready;
    logic [DEPTH-1:0]  ent_valid;
    logic [ADDR_W-1:0] ent_rd [DEPTH];
    logic              pend1, pend2;

    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;

    // The load unit owns the last free slot, so the ALU backs off when it contends.
    always_comb begin
        ld_ready  = count < CW'(DEPTH);
        alu_ready = (count < CW'(DEPTH)) && !(bus.ld_valid && (count == CW'(DEPTH - 1)));
    end

    assign ld_ent   = '{rd: bus.ld_rd,  data: bus.ld_data};
    assign alu_ent  = '{rd: bus.alu_rd, data: bus.alu_data};
    assign ld_push  = bus.ld_valid  && ld_ready  && (bus.ld_rd  != '0);
    assign alu_push = bus.alu_valid && alu_ready && (bus.alu_rd != '0);
    assign pop      = count != '0;

    always_comb begin
        push_a  = 1'b0;
        push_b  = 1'b0;
        byp     = 1'b0;
        ent_a   = ld_ent;
        ent_b   = alu_ent;
        byp_ent = ld_ent;
        if (ld_push) begin
            push_a = 1'b1;
            push_b = alu_push;
        end else if (alu_push) begin
            push_a = 1'b1;
            ent_a  = alu_ent;
        end
`ifdef REGFILE_WBQ_BYPASS_EN
        byp = (count == '0) && push_a;
        if (byp) begin
            byp_ent = ent_a;
            push_a  = push_b;
            ent_a   = ent_b;
            push_b  = 1'b0;
        end
`endif
    end

    wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_a_i    (push_a),
        .ent_a_i     (ent_a),
        .push_b_i    (push_b),
        .ent_b_i     (ent_b),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .ent_valid_o (ent_valid),
        .ent_rd_o    (ent_rd)
    );

    always_comb begin
        regwrite_d = pop || byp;
        rd_d       = rd_q;
        data_d     = data_q;
        if (pop) begin
            rd_d   = head.rd;
            data_d = head.data;
        end else if (byp) begin
            rd_d   = byp_ent.rd;
            data_d = byp_ent.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
        end
    end

    // Pending lookup sees only registered state: queued entries plus the write in flight.
    always_comb begin
        pend1 = regwrite_q && (rd_q == bus.chk_rs1);
        pend2 = regwrite_q && (rd_q == bus.chk_rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == bus.chk_rs1)) pend1 = 1'b1;
            if (ent_valid[i] && (ent_rd[i] == bus.chk_rs2)) pend2 = 1'b1;
        end
    end

    assign bus.pend_rs1   = pend1 && (bus.chk_rs1 != '0);
    assign bus.pend_rs2   = pend2 && (bus.chk_rs2 != '0);
    assign bus.ld_ready   = ld_ready;
    assign bus.alu_ready  = alu_ready;
    assign bus.RegWrite   = regwrite_q;
    assign bus.Rd         = rd_q;
    assign bus.Write_data = data_q;
    assign bus.count      = count;

endmodule
